// File: rtl/imem_loader_if.sv
// +----------------------------------------------------------------------------
// | imem_loader_if : byte-stream input, imem write port and status of the boot loader
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              start_o;
  logic              busy_o;
  logic              err_o;
  logic [ADDR_W:0]   words_o;

  // Loader side
  modport master (
    input  byte_i, byte_valid_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    output start_o, busy_o, err_o, words_o
  );

  // Byte source / memory / CPU side
  modport slave (
    output byte_i, byte_valid_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    input  start_o, busy_o, err_o, words_o
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------------
// | imem_loader : framed byte stream -> 32-bit imem writes, then CPU start
// | Optional trailing checksum byte: define LOADER_CHECKSUM_EN
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  imem_loader_if.master bus
);

  localparam logic [ADDR_W:0]   c_FULL     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHECK = 3'd4,
    S_ERR   = 3'd5
`endif
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_bidx;
  logic [23:0]       r_shift;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   r_words;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_start;
  logic              r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
  logic [7:0]        w_cks_sum;
`endif

  logic              w_ready;
  logic              w_accept;
  logic              w_is_sync;
  logic [ADDR_W:0]   w_count;
  logic [ADDR_W:0]   w_words_nxt;
  logic              w_last;

  assign w_ready     = (r_state != S_DONE);
  assign w_accept    = bus.byte_valid_i & w_ready;
  assign w_is_sync   = (bus.byte_i == SYNC);
  assign w_words_nxt = r_words + c_WORD_ONE;
  assign w_last      = (w_words_nxt == r_cnt);
`ifdef LOADER_CHECKSUM_EN
  assign w_cks_sum   = r_sum + bus.byte_i;
`endif

  // A count byte of zero stands for a full memory of 2^ADDR_W words
  always_comb begin
    w_count = c_FULL;
    if (bus.byte_i != 8'd0) begin
      w_count = (ADDR_W+1)'(bus.byte_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_bidx  <= 2'd0;
      r_shift <= 24'd0;
      r_cnt   <= c_FULL;
      r_words <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 32'd0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_sync) begin
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            r_cnt   <= w_count;
            r_addr  <= '0;
            r_bidx  <= 2'd0;
            r_words <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= 8'd0;
`endif
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift <= {bus.byte_i, r_shift[23:8]};
            r_bidx  <= r_bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= w_cks_sum;
`endif
            // Fourth byte completes the word; the address wraps silently after a full frame
            if (r_bidx == 2'd3) begin
              r_we    <= 1'b1;
              r_waddr <= r_addr;
              r_wdata <= {bus.byte_i, r_shift};
              r_addr  <= r_addr + c_ADDR_ONE;
              r_words <= w_words_nxt;
              if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                r_state <= S_DONE;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            if (w_cks_sum == 8'd0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        S_ERR: begin
          if (w_accept && w_is_sync) begin
            r_err   <= 1'b0;
            r_state <= S_COUNT;
          end
        end
`endif
        S_DONE: begin
          r_start <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready_o = w_ready;
  assign bus.imem_we_o    = r_we;
  assign bus.imem_addr_o  = r_waddr;
  assign bus.imem_data_o  = r_wdata;
  assign bus.start_o      = r_start;
  assign bus.words_o      = r_words;
`ifdef LOADER_CHECKSUM_EN
  assign bus.busy_o       = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
  assign bus.err_o        = r_err;
`else
  assign bus.busy_o       = (r_state == S_COUNT) || (r_state == S_DATA);
  assign bus.err_o        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +----------------------------------------------------------------------------
// | tb_imem_loader : directed + randomized frames against a frame-level write model
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          last_acc;
  wr_t         got_q[$];
  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [31:0] frame_words[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Every cycle with the write strobe high is one observed memory write
  always @(negedge clk_i) begin
    if (bus.imem_we_o === 1'b1) begin
      mon_w.addr = int'(bus.imem_addr_o);
      mon_w.data = bus.imem_data_o;
      mon_w.cyc  = cyc;
      got_q.push_back(mon_w);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(bus.byte_ready_o), 64'd1);
    chk({tag, "_we"},    64'(bus.imem_we_o),    64'd0);
    chk({tag, "_addr"},  64'(bus.imem_addr_o),  64'd0);
    chk({tag, "_data"},  64'(bus.imem_data_o),  64'd0);
    chk({tag, "_start"}, 64'(bus.start_o),      64'd0);
    chk({tag, "_busy"},  64'(bus.busy_o),       64'd0);
    chk({tag, "_err"},   64'(bus.err_o),        64'd0);
    chk({tag, "_words"}, 64'(bus.words_o),      64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.byte_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles and returns just after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc;
    repeat (gap) begin
      @(negedge clk_i);
      bus.byte_valid_i = 1'b0;
    end
    @(negedge clk_i);
    bus.byte_i = b;
    bus.byte_valid_i = 1'b1;
    waitc = 0;
    while (bus.byte_ready_o !== 1'b1 && waitc < 20) begin
      @(negedge clk_i);
      waitc++;
    end
    if (waitc >= 20) chk("ready_timeout", 64'(bus.byte_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    last_acc = cyc;
  endtask

  // Sends SYNC, count, little-endian words and (if built) checksum; the model
  // expects word i at address i mod 2^ADDR_W in the cycle its 4th byte is taken.
  task automatic send_frame(input int gap_lo, input int gap_hi, input bit bad_cks,
                            input bit chk_err_clear);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [7:0]  nb;
    logic [31:0] w;
    int          nw;
    wr_t         e;
    nw  = frame_words.size();
    nb  = nw[7:0];
    sum = 8'd0;
    got_q.delete();
    exp_q.delete();
    send_byte(8'hA5, $urandom_range(gap_hi, gap_lo));
    if (chk_err_clear) chk("err_clear_on_sync", 64'(bus.err_o), 64'd0);
    send_byte(nb, $urandom_range(gap_hi, gap_lo));
    for (int i = 0; i < nw; i++) begin
      w = frame_words[i];
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        sum = sum + b;
        send_byte(b, $urandom_range(gap_hi, gap_lo));
      end
      e.addr = i % (1 << ADDR_W);
      e.data = w;
      e.cyc  = last_acc;
      exp_q.push_back(e);
    end
`ifdef LOADER_CHECKSUM_EN
    b = 8'h00 - sum;
    if (bad_cks) b = b ^ 8'hFF;
    send_byte(b, $urandom_range(gap_hi, gap_lo));
`else
    if (bad_cks) $display("note: checksum not built, bad_cks ignored");
`endif
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    chk("start_not_yet", 64'(bus.start_o), 64'd0);
    @(negedge clk_i);
`ifdef LOADER_CHECKSUM_EN
    chk("start_after_final", 64'(bus.start_o), 64'(!bad_cks));
`else
    chk("start_after_final", 64'(bus.start_o), 64'd1);
`endif
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = frame_words.size();
    repeat (3) @(negedge clk_i);
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
      chk({tag, "_wcyc"}, 64'(got_q[i].cyc),  64'(exp_q[i].cyc));
    end
    chk({tag, "_words"}, 64'(bus.words_o), 64'(n));
    chk({tag, "_start"}, 64'(bus.start_o), 64'd1);
    chk({tag, "_busy"},  64'(bus.busy_o),  64'd0);
    chk({tag, "_err"},   64'(bus.err_o),   64'd0);
  endtask

  initial begin
    int sz;
    int nr;
    bus.byte_i = 8'h00;
    bus.byte_valid_i = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_vals("reset");

    // Single word at full rate
    frame_words = '{32'h12345678};
    send_frame(0, 0, 1'b0, 1'b0);
    check_frame("one_word");

    // Leading junk is ignored, then a two-word frame
    do_reset();
    got_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h3C, 0);
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    chk("junk_busy", 64'(bus.busy_o), 64'd0);
    chk("junk_nowrite", 64'(got_q.size()), 64'd0);
    frame_words = '{32'h20080005, 32'h8C090000};
    send_frame(0, 0, 1'b0, 1'b0);
    check_frame("two_word");

    // Full memory (count byte 0), full rate, random contents
    do_reset();
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back($urandom);
    send_frame(0, 0, 1'b0, 1'b0);
    check_frame("full_mem");
    chk("full_mem_last_addr", 64'(got_q[got_q.size()-1].addr), 64'd255);

    // Valid toggling every other cycle, then input refused in DONE
    do_reset();
    frame_words = '{32'h12345678};
    send_frame(1, 1, 1'b0, 1'b0);
    check_frame("gapped");
    sz = got_q.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      bus.byte_i = (i == 0) ? 8'hA5 : 8'($urandom);
      bus.byte_valid_i = 1'b1;
      chk("done_ready", 64'(bus.byte_ready_o), 64'd0);
    end
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("done_nowrite", 64'(got_q.size()), 64'(sz));
    chk("done_start_held", 64'(bus.start_o), 64'd1);

    // Reset mid-word, with a 4th byte presented on the reset edge
    do_reset();
    got_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk_i);
    bus.byte_i = 8'h44;
    bus.byte_valid_i = 1'b1;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.byte_valid_i = 1'b0;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk_i);
    chk("midreset_nowrite", 64'(got_q.size()), 64'd0);
    frame_words = '{$urandom};
    send_frame(0, 0, 1'b0, 1'b0);
    check_frame("after_midreset");

    // Random frame lengths and random stalls
    for (int k = 0; k < 4; k++) begin
      do_reset();
      nr = $urandom_range(40, 1);
      frame_words.delete();
      for (int i = 0; i < nr; i++) frame_words.push_back($urandom);
      send_frame(0, 2, 1'b0, 1'b0);
      check_frame("random");
    end

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum, then a retry that clears the error on SYNC
    do_reset();
    frame_words = '{32'h00000001};
    send_frame(0, 0, 1'b1, 1'b0);
    chk("bad_cks_err",   64'(bus.err_o),        64'd1);
    chk("bad_cks_start", 64'(bus.start_o),      64'd0);
    chk("bad_cks_ready", 64'(bus.byte_ready_o), 64'd1);
    chk("bad_cks_busy",  64'(bus.busy_o),       64'd0);
    send_frame(0, 0, 1'b0, 1'b1);
    check_frame("retry");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
